// File: rtl/relu_pkg.sv
// Shared types and helpers for the requantising activation blocks.
package relu_pkg;

  typedef enum logic {
    RELU_PLAIN = 1'b0,
    RELU_CLIP  = 1'b1
  } relu_mode_e;

  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } stream_flags_t;

  localparam int RS_W = 64;

  // Round-half-up arithmetic right shift; wide enough that the bias add never overflows.
  function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] x,
                                                         input int unsigned shift);
    logic signed [RS_W-1:0] half;
    half = 64'sd1 <<< (shift - 1);
    return (x + half) >>> shift;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// One channel of relu_requant: stage-1 round/shift, stage-2 clamp to [0, limit].
module relu_lane
  import relu_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int SHIFT = 13,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  sample,
  input  logic [OUT_W-1:0]        limit,
  output logic [OUT_W-1:0]        act_p2,
  output logic                    sat_p2
);

  localparam int R_W = IN_W - SHIFT + 1;

  logic signed [R_W-1:0] r_p1;
  logic signed [63:0]    r_wide;
  logic signed [63:0]    lim_wide;
  logic [OUT_W-1:0]      act_nxt;
  logic                  sat_nxt;

  // Stage 1: rounded, shifted accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1 <= '0;
    end else if (en) begin
      r_p1 <= R_W'(round_shift(64'(sample), SHIFT));
    end
  end

  always_comb begin
    r_wide   = 64'(r_p1);
    lim_wide = 64'(limit);
    act_nxt  = r_wide[OUT_W-1:0];
    sat_nxt  = 1'b0;
    if (r_wide < 0) begin
      act_nxt = '0;
    end else if (r_wide > lim_wide) begin
      act_nxt = limit;
      sat_nxt = 1'b1;
    end
  end

  // Stage 2: clamped activation and its saturation flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_p2 <= '0;
      sat_p2 <= 1'b0;
    end else if (en) begin
      act_p2 <= act_nxt;
      sat_p2 <= sat_nxt;
    end
  end

endmodule

// File: rtl/relu_requant.sv
// Multi-channel ReLU / clipped ReLU requantiser with 2-stage ready/valid pipeline.
// Optional per-frame saturation counter enabled by defining RELU_SAT_CNT_EN.
module relu_requant
  import relu_pkg::*;
#(
  parameter int CH    = 1,
  parameter int IN_W  = 24,
  parameter int SHIFT = 13,
  parameter int OUT_W = 8,
  parameter int CNT_W = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CH*IN_W-1:0]  data_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                sop_i,
  input  logic                eop_i,
  input  logic                sof_i,
  input  logic                eof_i,
  input  logic                mode_i,
  input  logic [OUT_W-1:0]    clip_i,
  output logic [CH*OUT_W-1:0] data_o,
  output logic                data_valid_o,
  input  logic                ready_i,
  output logic                sop_o,
  output logic                eop_o,
  output logic                sof_o,
  output logic                eof_o,
  output logic [CNT_W-1:0]    sat_cnt_o,
  output logic                sat_cnt_valid_o
);

  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  logic          adv, acc;
  stream_flags_t flags_in, flags_p1, flags_p2;
  logic          vld_p1;
  relu_mode_e    mode_q, mode_p0;
  logic [OUT_W-1:0] clip_q, clip_p0, limit_p0, limit_p1;
  logic [CH-1:0] sat_p2;

  assign adv      = ready_i || !data_valid_o;
  assign ready_o  = adv;
  assign acc      = valid_i && adv;
  assign flags_in = '{sop: sop_i, eop: eop_i, sof: sof_i, eof: eof_i};

  // The sof beat itself already uses the freshly loaded mode/clip.
  always_comb begin
    mode_p0 = mode_q;
    clip_p0 = clip_q;
    if (acc && sof_i) begin
      mode_p0 = relu_mode_e'(mode_i);
      clip_p0 = clip_i;
    end
    limit_p0 = (mode_p0 == RELU_CLIP) ? clip_p0 : OUT_MAX;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= RELU_PLAIN;
      clip_q <= OUT_MAX;
    end else begin
      mode_q <= mode_p0;
      clip_q <= clip_p0;
    end
  end

  // Stage 1 / stage 2 control, markers and the per-beat limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1       <= 1'b0;
      flags_p1     <= '0;
      limit_p1     <= '0;
      data_valid_o <= 1'b0;
      flags_p2     <= '0;
    end else if (adv) begin
      vld_p1       <= acc;
      flags_p1     <= acc ? flags_in : '0;
      limit_p1     <= limit_p0;
      data_valid_o <= vld_p1;
      flags_p2     <= flags_p1;
    end
  end

  assign sop_o = flags_p2.sop;
  assign eop_o = flags_p2.eop;
  assign sof_o = flags_p2.sof;
  assign eof_o = flags_p2.eof;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    relu_lane #(.IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (adv),
      .sample (data_i[g*IN_W +: IN_W]),
      .limit  (limit_p1),
      .act_p2 (data_o[g*OUT_W +: OUT_W]),
      .sat_p2 (sat_p2[g])
    );
  end

`ifdef RELU_SAT_CNT_EN
  logic             leave;
  logic [CNT_W-1:0] cnt_q, beat_sat, base, total;
  logic [CNT_W:0]   sum;

  assign leave = adv && data_valid_o;

  always_comb begin
    beat_sat = '0;
    for (int i = 0; i < CH; i++) begin
      beat_sat = beat_sat + CNT_W'(sat_p2[i]);
    end
    base  = flags_p2.sof ? '0 : cnt_q;
    sum   = {1'b0, base} + {1'b0, beat_sat};
    total = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      sat_cnt_o       <= '0;
      sat_cnt_valid_o <= 1'b0;
    end else begin
      sat_cnt_valid_o <= leave && flags_p2.eof;
      if (leave) begin
        cnt_q <= total;
        if (flags_p2.eof) begin
          sat_cnt_o <= total;
        end
      end
    end
  end
`else
  logic unused_sat;
  assign unused_sat      = ^sat_p2;
  assign sat_cnt_o       = '0;
  assign sat_cnt_valid_o = 1'b0;
`endif

endmodule
